// File: rtl/icb_arb_2to1_pkg.sv
// Shared ICB widths and helpers for the 2:1 ICB arbiter.
// Holds the ICB bus widths, the default outstanding depth and the
// packed command payload used on both sides of the arbiter.
package icb_arb_2to1_pkg;

  localparam int unsigned MYRISCV_ADDRBUS    = 32;
  localparam int unsigned MYRISCV_DATABUS    = 32;
  localparam int unsigned MYRISCV_DATADW     = 32;
  localparam int unsigned MYRISCV_MASKW      = MYRISCV_DATADW / 8;
  localparam int unsigned ICB_ARB_OUTS_DEPTH = 4;

  // Command payload travelling with a command handshake.
  typedef struct packed {
    logic [MYRISCV_ADDRBUS-1:0] addr;
    logic                       read;
    logic [MYRISCV_DATABUS-1:0] wdata;
    logic [MYRISCV_MASKW-1:0]   wmask;
  } icb_cmd_t;

  // Round-robin tie-break: the master not granted last wins.
  function automatic logic rr_pick(input logic rr_last);
    return ~rr_last;
  endfunction

endpackage

// File: rtl/icb_arb_id_fifo.sv
// In-order 1-bit ID FIFO recording which master owns each outstanding
// command.
// Ports: clk, rst_n (async active-low), i_push/i_din write side,
// i_pop read side, o_head (ID at head), o_full, o_empty.
// Push is ignored when full and pop is ignored when empty.
module icb_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage, wrapping pointers (power-of-two depth) and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/icb_arb_2to1.sv
// Two-master to one-slave ICB arbiter in front of the gpu_simple slave.
// Master 0 is the CPU (biu_master) path, master 1 the DMA/blitter.
// Ports: clk, rst (async active-low); m0_/m1_ master ICB command and
// response channels; s_ slave ICB command and response channels.
// Command and response paths are combinational; only the ID FIFO,
// the round-robin pointer and the grant lock are registered.
// While rst is low every output is held at 0.
// Build option: define ICB_ARB_FIXED_PRIO_EN for strict master-0 priority
// on unlocked arbitration instead of round-robin.
module icb_arb_2to1
  import icb_arb_2to1_pkg::*;
#(
  parameter int unsigned OUTS_DEPTH = ICB_ARB_OUTS_DEPTH,
  parameter int unsigned OUTS_AW    = 2
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       m0_icb_cmd_vld,
  output logic                       m0_icb_cmd_rdy,
  input  logic [MYRISCV_ADDRBUS-1:0] m0_icb_cmd_addr,
  input  logic                       m0_icb_cmd_read,
  input  logic [MYRISCV_DATABUS-1:0] m0_icb_cmd_wdata,
  input  logic [MYRISCV_MASKW-1:0]   m0_icb_cmd_wmask,
  output logic                       m0_icb_rsp_vld,
  input  logic                       m0_icb_rsp_rdy,
  output logic [MYRISCV_DATABUS-1:0] m0_icb_rsp_rdata,
  output logic                       m0_icb_rsp_err,

  input  logic                       m1_icb_cmd_vld,
  output logic                       m1_icb_cmd_rdy,
  input  logic [MYRISCV_ADDRBUS-1:0] m1_icb_cmd_addr,
  input  logic                       m1_icb_cmd_read,
  input  logic [MYRISCV_DATABUS-1:0] m1_icb_cmd_wdata,
  input  logic [MYRISCV_MASKW-1:0]   m1_icb_cmd_wmask,
  output logic                       m1_icb_rsp_vld,
  input  logic                       m1_icb_rsp_rdy,
  output logic [MYRISCV_DATABUS-1:0] m1_icb_rsp_rdata,
  output logic                       m1_icb_rsp_err,

  output logic                       s_icb_cmd_vld,
  input  logic                       s_icb_cmd_rdy,
  output logic [MYRISCV_ADDRBUS-1:0] s_icb_cmd_addr,
  output logic                       s_icb_cmd_read,
  output logic [MYRISCV_DATABUS-1:0] s_icb_cmd_wdata,
  output logic [MYRISCV_MASKW-1:0]   s_icb_cmd_wmask,
  input  logic                       s_icb_rsp_vld,
  output logic                       s_icb_rsp_rdy,
  input  logic [MYRISCV_DATABUS-1:0] s_icb_rsp_rdata,
  input  logic                       s_icb_rsp_err
);

  logic     r_rr_last;
  logic     r_lock_vld;
  logic     r_lock_id;

  icb_cmd_t w_m0_cmd;
  icb_cmd_t w_m1_cmd;
  icb_cmd_t w_s_cmd;
  logic     w_gnt_vld;
  logic     w_gnt_id;
  logic     w_gnt_req;
  logic     w_cmd_ok;
  logic     w_push;
  logic     w_pop;
  logic     w_full;
  logic     w_empty;
  logic     w_head;
  logic     w_rsp_go;

  assign w_m0_cmd = {m0_icb_cmd_addr, m0_icb_cmd_read, m0_icb_cmd_wdata, m0_icb_cmd_wmask};
  assign w_m1_cmd = {m1_icb_cmd_addr, m1_icb_cmd_read, m1_icb_cmd_wdata, m1_icb_cmd_wmask};

  // Grant selection: a stalled command keeps its master; otherwise arbitrate.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if (!rst) begin
      w_gnt_vld = 1'b0;
    end else if (r_lock_vld) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = r_lock_id;
    end else if (m0_icb_cmd_vld && m1_icb_cmd_vld) begin
      w_gnt_vld = 1'b1;
`ifdef ICB_ARB_FIXED_PRIO_EN
      w_gnt_id  = 1'b0;
`else
      w_gnt_id  = rr_pick(r_rr_last);
`endif
    end else if (m0_icb_cmd_vld) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b0;
    end else if (m1_icb_cmd_vld) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b1;
    end
  end

  // Command path: granted bundle to the slave, zeros when nothing granted.
  assign w_gnt_req = w_gnt_id ? m1_icb_cmd_vld : m0_icb_cmd_vld;
  assign w_s_cmd   = w_gnt_vld ? (w_gnt_id ? w_m1_cmd : w_m0_cmd) : '0;
  assign w_cmd_ok  = w_gnt_vld & s_icb_cmd_rdy & ~w_full;
  assign w_push    = s_icb_cmd_vld & s_icb_cmd_rdy;

  assign s_icb_cmd_vld   = w_gnt_vld & w_gnt_req & ~w_full;
  assign s_icb_cmd_addr  = w_s_cmd.addr;
  assign s_icb_cmd_read  = w_s_cmd.read;
  assign s_icb_cmd_wdata = w_s_cmd.wdata;
  assign s_icb_cmd_wmask = w_s_cmd.wmask;
  assign m0_icb_cmd_rdy  = w_cmd_ok & ~w_gnt_id;
  assign m1_icb_cmd_rdy  = w_cmd_ok & w_gnt_id;

  // Response path: head of the ID FIFO owns the current slave response.
  assign w_rsp_go         = rst & s_icb_rsp_vld & ~w_empty;
  assign m0_icb_rsp_vld   = w_rsp_go & ~w_head;
  assign m1_icb_rsp_vld   = w_rsp_go & w_head;
  assign s_icb_rsp_rdy    = rst & ~w_empty & (w_head ? m1_icb_rsp_rdy : m0_icb_rsp_rdy);
  assign w_pop            = s_icb_rsp_vld & s_icb_rsp_rdy;
  assign m0_icb_rsp_rdata = rst ? s_icb_rsp_rdata : '0;
  assign m1_icb_rsp_rdata = rst ? s_icb_rsp_rdata : '0;
  assign m0_icb_rsp_err   = rst & s_icb_rsp_err;
  assign m1_icb_rsp_err   = rst & s_icb_rsp_err;

  // Round-robin pointer and grant lock for a command stalled by the slave.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_last  <= 1'b1;
      r_lock_vld <= 1'b0;
      r_lock_id  <= 1'b0;
    end else begin
      if (w_push) begin
        r_rr_last <= w_gnt_id;
      end
      r_lock_vld <= s_icb_cmd_vld & ~s_icb_cmd_rdy;
      if (s_icb_cmd_vld && !s_icb_cmd_rdy) begin
        r_lock_id <= w_gnt_id;
      end
    end
  end

  icb_arb_id_fifo #(
    .DEPTH (OUTS_DEPTH),
    .AW    (OUTS_AW)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_din   (w_gnt_id),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_icb_arb_2to1.sv
// Self-checking bench for icb_arb_2to1: a queue-based reference model is
// compared against the DUT on every falling edge, plus directed scenarios
// with hand-computed expectations.
module tb_icb_arb_2to1;
  import icb_arb_2to1_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic                       m0_icb_cmd_vld = 0, m1_icb_cmd_vld = 0;
  logic                       m0_icb_cmd_rdy, m1_icb_cmd_rdy;
  logic [MYRISCV_ADDRBUS-1:0] m0_icb_cmd_addr = '0, m1_icb_cmd_addr = '0;
  logic                       m0_icb_cmd_read = 0, m1_icb_cmd_read = 0;
  logic [MYRISCV_DATABUS-1:0] m0_icb_cmd_wdata = '0, m1_icb_cmd_wdata = '0;
  logic [MYRISCV_MASKW-1:0]   m0_icb_cmd_wmask = '0, m1_icb_cmd_wmask = '0;
  logic                       m0_icb_rsp_vld, m1_icb_rsp_vld;
  logic                       m0_icb_rsp_rdy = 0, m1_icb_rsp_rdy = 0;
  logic [MYRISCV_DATABUS-1:0] m0_icb_rsp_rdata, m1_icb_rsp_rdata;
  logic                       m0_icb_rsp_err, m1_icb_rsp_err;
  logic                       s_icb_cmd_vld;
  logic                       s_icb_cmd_rdy = 0;
  logic [MYRISCV_ADDRBUS-1:0] s_icb_cmd_addr;
  logic                       s_icb_cmd_read;
  logic [MYRISCV_DATABUS-1:0] s_icb_cmd_wdata;
  logic [MYRISCV_MASKW-1:0]   s_icb_cmd_wmask;
  logic                       s_icb_rsp_vld = 0;
  logic                       s_icb_rsp_rdy;
  logic [MYRISCV_DATABUS-1:0] s_icb_rsp_rdata = '0;
  logic                       s_icb_rsp_err = 0;

  int n_vec = 0;
  int n_err = 0;
  int glog[$];

  int mq[$];
  int mdl_rr = 1;
  bit mdl_lock = 0;
  int mdl_lock_id = 0;

  always #5 clk = ~clk;

  icb_arb_2to1 dut (
    .clk(clk), .rst(rst),
    .m0_icb_cmd_vld(m0_icb_cmd_vld), .m0_icb_cmd_rdy(m0_icb_cmd_rdy),
    .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_vld(m0_icb_rsp_vld), .m0_icb_rsp_rdy(m0_icb_rsp_rdy),
    .m0_icb_rsp_rdata(m0_icb_rsp_rdata), .m0_icb_rsp_err(m0_icb_rsp_err),
    .m1_icb_cmd_vld(m1_icb_cmd_vld), .m1_icb_cmd_rdy(m1_icb_cmd_rdy),
    .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_vld(m1_icb_rsp_vld), .m1_icb_rsp_rdy(m1_icb_rsp_rdy),
    .m1_icb_rsp_rdata(m1_icb_rsp_rdata), .m1_icb_rsp_err(m1_icb_rsp_err),
    .s_icb_cmd_vld(s_icb_cmd_vld), .s_icb_cmd_rdy(s_icb_cmd_rdy),
    .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_vld(s_icb_rsp_vld), .s_icb_rsp_rdy(s_icb_rsp_rdy),
    .s_icb_rsp_rdata(s_icb_rsp_rdata), .s_icb_rsp_err(s_icb_rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outstanding owners kept as a plain queue.
  always @(negedge clk) begin : cmp
    logic        vq[2];
    logic [31:0] ad[2], rd[2], wd[2], wm[2];
    logic        rr[2];
    logic        erdy[2], ersp[2];
    logic        gv, ev, esrdy, full, empty;
    int          g;
    if (!rst) begin
      mq.delete();
      mdl_rr = 1; mdl_lock = 0; mdl_lock_id = 0;
      chk("rst_s_cmd_vld", s_icb_cmd_vld, 0);
      chk("rst_s_cmd_addr", s_icb_cmd_addr, 0);
      chk("rst_s_cmd_read", s_icb_cmd_read, 0);
      chk("rst_s_cmd_wdata", s_icb_cmd_wdata, 0);
      chk("rst_s_cmd_wmask", s_icb_cmd_wmask, 0);
      chk("rst_m0_cmd_rdy", m0_icb_cmd_rdy, 0);
      chk("rst_m1_cmd_rdy", m1_icb_cmd_rdy, 0);
      chk("rst_m0_rsp_vld", m0_icb_rsp_vld, 0);
      chk("rst_m1_rsp_vld", m1_icb_rsp_vld, 0);
      chk("rst_s_rsp_rdy", s_icb_rsp_rdy, 0);
      chk("rst_m0_rdata", m0_icb_rsp_rdata, 0);
      chk("rst_m1_err", m1_icb_rsp_err, 0);
    end else begin
      vq[0] = m0_icb_cmd_vld;  vq[1] = m1_icb_cmd_vld;
      ad[0] = m0_icb_cmd_addr; ad[1] = m1_icb_cmd_addr;
      rd[0] = 32'(m0_icb_cmd_read);  rd[1] = 32'(m1_icb_cmd_read);
      wd[0] = m0_icb_cmd_wdata; wd[1] = m1_icb_cmd_wdata;
      wm[0] = 32'(m0_icb_cmd_wmask); wm[1] = 32'(m1_icb_cmd_wmask);
      rr[0] = m0_icb_rsp_rdy;  rr[1] = m1_icb_rsp_rdy;
      full  = (mq.size() >= DEPTH);
      empty = (mq.size() == 0);
      gv = 0; g = 0;
      if (mdl_lock) begin
        gv = 1; g = mdl_lock_id;
      end else if (vq[0] && vq[1]) begin
        gv = 1;
`ifdef ICB_ARB_FIXED_PRIO_EN
        g = 0;
`else
        g = (mdl_rr == 1) ? 0 : 1;
`endif
      end else if (vq[0]) begin
        gv = 1; g = 0;
      end else if (vq[1]) begin
        gv = 1; g = 1;
      end
      ev = gv && vq[g] && !full;
      erdy[0] = 0; erdy[1] = 0;
      if (gv && s_icb_cmd_rdy && !full) erdy[g] = 1;
      ersp[0] = 0; ersp[1] = 0; esrdy = 0;
      if (!empty) begin
        ersp[mq[0]] = s_icb_rsp_vld;
        esrdy = rr[mq[0]];
      end
      chk("s_cmd_vld", s_icb_cmd_vld, ev);
      chk("s_cmd_addr", s_icb_cmd_addr, gv ? ad[g] : 0);
      chk("s_cmd_read", s_icb_cmd_read, gv ? rd[g] : 0);
      chk("s_cmd_wdata", s_icb_cmd_wdata, gv ? wd[g] : 0);
      chk("s_cmd_wmask", s_icb_cmd_wmask, gv ? wm[g] : 0);
      chk("m0_cmd_rdy", m0_icb_cmd_rdy, erdy[0]);
      chk("m1_cmd_rdy", m1_icb_cmd_rdy, erdy[1]);
      chk("m0_rsp_vld", m0_icb_rsp_vld, ersp[0]);
      chk("m1_rsp_vld", m1_icb_rsp_vld, ersp[1]);
      chk("s_rsp_rdy", s_icb_rsp_rdy, esrdy);
      chk("m0_rsp_rdata", m0_icb_rsp_rdata, s_icb_rsp_rdata);
      chk("m1_rsp_rdata", m1_icb_rsp_rdata, s_icb_rsp_rdata);
      chk("m0_rsp_err", m0_icb_rsp_err, s_icb_rsp_err);
      chk("m1_rsp_err", m1_icb_rsp_err, s_icb_rsp_err);
      if (m0_icb_cmd_vld && m0_icb_cmd_rdy) glog.push_back(0);
      if (m1_icb_cmd_vld && m1_icb_cmd_rdy) glog.push_back(1);
      if (s_icb_rsp_vld && esrdy) void'(mq.pop_front());
      if (ev && s_icb_cmd_rdy) begin
        mq.push_back(g);
        mdl_rr = g;
      end
      mdl_lock    = ev && !s_icb_cmd_rdy;
      mdl_lock_id = g;
    end
  end

  initial begin
    int exp_rr[4];
    int iss[4];
`ifdef ICB_ARB_FIXED_PRIO_EN
    exp_rr = '{0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 0, 1};
`endif
    iss = '{0, 1, 1, 0};

    repeat (3) cyc();
    rst = 1;
    cyc();

    // Both masters requesting, slave always ready, responses drained.
    glog.delete();
    m0_icb_cmd_vld = 1; m0_icb_cmd_addr = 32'h0000_1000;
    m1_icb_cmd_vld = 1; m1_icb_cmd_addr = 32'h0000_2000; m1_icb_cmd_read = 1;
    m1_icb_cmd_wmask = 4'hF;
    s_icb_cmd_rdy = 1; s_icb_rsp_vld = 1; s_icb_rsp_rdata = 32'hCAFE_0001;
    m0_icb_rsp_rdy = 1; m1_icb_rsp_rdy = 1;
    repeat (4) cyc();
    chk("rr_count", glog.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_seq%0d", i), glog[i], exp_rr[i]);
    m0_icb_cmd_vld = 0; m1_icb_cmd_vld = 0;
    repeat (3) cyc();
    s_icb_rsp_vld = 0;
    cyc();

    // Single master 0 read and its response.
    m0_icb_cmd_vld = 1; m0_icb_cmd_addr = 32'h8000_0000; m0_icb_cmd_read = 1;
    #1;
    chk("t1_s_addr", s_icb_cmd_addr, 32'h8000_0000);
    chk("t1_s_vld", s_icb_cmd_vld, 1);
    chk("t1_m0_rdy", m0_icb_cmd_rdy, 1);
    cyc();
    m0_icb_cmd_vld = 0; s_icb_rsp_vld = 1; s_icb_rsp_rdata = 32'h1234_5678; s_icb_rsp_err = 0;
    #1;
    chk("t1_m0_rsp_vld", m0_icb_rsp_vld, 1);
    chk("t1_m1_rsp_vld", m1_icb_rsp_vld, 0);
    chk("t1_m0_rdata", m0_icb_rsp_rdata, 32'h1234_5678);
    cyc();
    s_icb_rsp_vld = 0;
    #1;
    chk("t1_empty_rsp_rdy", s_icb_rsp_rdy, 0);
    chk("t1_idle_addr", s_icb_cmd_addr, 0);
    cyc();

    // Grant lock: m1 stalled three cycles while m0 also requests.
    m1_icb_cmd_vld = 1; m1_icb_cmd_addr = 32'h0000_0A10; s_icb_cmd_rdy = 0;
    #1;
    chk("t3_addr_c1", s_icb_cmd_addr, 32'h0000_0A10);
    cyc();
    m0_icb_cmd_vld = 1; m0_icb_cmd_addr = 32'h0000_0B20;
    #1;
    chk("t3_addr_c2", s_icb_cmd_addr, 32'h0000_0A10);
    chk("t3_m0_rdy_c2", m0_icb_cmd_rdy, 0);
    cyc();
    #1;
    chk("t3_addr_c3", s_icb_cmd_addr, 32'h0000_0A10);
    cyc();
    s_icb_cmd_rdy = 1;
    #1;
    chk("t3_m1_rdy_c4", m1_icb_cmd_rdy, 1);
    chk("t3_m0_rdy_c4", m0_icb_cmd_rdy, 0);
    cyc();
    m1_icb_cmd_vld = 0;
    #1;
    chk("t3_m0_after", m0_icb_cmd_rdy, 1);
    chk("t3_addr_after", s_icb_cmd_addr, 32'h0000_0B20);
    cyc();
    m0_icb_cmd_vld = 0; s_icb_rsp_vld = 1;
    repeat (3) cyc();
    s_icb_rsp_vld = 0;
    cyc();

    // Fill the ID FIFO, then show no push-on-pop when full.
    m0_icb_cmd_vld = 1; m0_icb_cmd_addr = 32'h0000_0C00; m0_icb_cmd_read = 0;
    m0_icb_cmd_wdata = 32'hDEAD_BEEF; m0_icb_cmd_wmask = 4'h3;
    repeat (4) cyc();
    chk("t4_mdl_cnt", mq.size(), 4);
    chk("t4_full_rdy", m0_icb_cmd_rdy, 0);
    chk("t4_full_svld", s_icb_cmd_vld, 0);
    cyc();
    s_icb_rsp_vld = 1;
    #1;
    chk("t4_pop_svld", s_icb_cmd_vld, 0);
    chk("t4_pop_rdy", m0_icb_cmd_rdy, 0);
    cyc();
    s_icb_rsp_vld = 0;
    #1;
    chk("t4_after_rdy", m0_icb_cmd_rdy, 1);
    chk("t4_after_svld", s_icb_cmd_vld, 1);
    cyc();
    m0_icb_cmd_vld = 0; s_icb_rsp_vld = 1;
    repeat (5) cyc();
    s_icb_rsp_vld = 0;
    cyc();

    // Interleaved issue 0,1,1,0 and in-order responses, error on the third.
    for (int i = 0; i < 4; i++) begin
      m0_icb_cmd_vld = (iss[i] == 0);
      m1_icb_cmd_vld = (iss[i] == 1);
      cyc();
    end
    m0_icb_cmd_vld = 0; m1_icb_cmd_vld = 0;
    for (int i = 0; i < 4; i++) begin
      s_icb_rsp_vld = 1; s_icb_rsp_rdata = 32'h0000_00A0 + 32'(i); s_icb_rsp_err = (i == 2);
      #1;
      chk($sformatf("t5_m0_vld%0d", i), m0_icb_rsp_vld, (iss[i] == 0));
      chk($sformatf("t5_m1_vld%0d", i), m1_icb_rsp_vld, (iss[i] == 1));
      chk($sformatf("t5_err%0d", i), iss[i] ? m1_icb_rsp_err : m0_icb_rsp_err, (i == 2));
      cyc();
    end
    s_icb_rsp_vld = 0; s_icb_rsp_err = 0;
    cyc();

    // Reset with two outstanding commands.
    m0_icb_cmd_vld = 1;
    cyc();
    m0_icb_cmd_vld = 0; m1_icb_cmd_vld = 1;
    cyc();
    m0_icb_cmd_vld = 1; m1_icb_cmd_vld = 1; s_icb_cmd_rdy = 0; s_icb_rsp_vld = 1;
    #1;
    chk("t6_pre_rsp_vld", m0_icb_rsp_vld, 1);
    rst = 0;
    #1;
    chk("t6_rst_svld", s_icb_cmd_vld, 0);
    chk("t6_rst_rsp_vld", m0_icb_rsp_vld, 0);
    chk("t6_rst_srdy", s_icb_rsp_rdy, 0);
    cyc();
    rst = 1; s_icb_cmd_rdy = 1; s_icb_rsp_vld = 0;
    #1;
    chk("t6_tie_m0", m0_icb_cmd_rdy, 1);
    chk("t6_tie_m1", m1_icb_cmd_rdy, 0);
    chk("t6_empty", s_icb_rsp_rdy, 0);
    cyc();
    m0_icb_cmd_vld = 0; m1_icb_cmd_vld = 0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
